uart_byte_rx: RTL and testbench
===============================

// Module: uart_byte_rx
// PURPOSE
//   Serial-to-parallel UART receiver, 8N1, LSB first, 16x oversampled. Recovers
//   bytes from the uart_rx pin and emits them with a one-cycle rx_done strobe.
//   It is the receive-side counterpart of the byte transmitter and sits between
//   the board RX pin and the command/data consumer logic.
// PARAMETERS
//   CLOCK_FREQ  50_000_000  system clock frequency in Hz
//   BAUD        9600        line rate in bit/s
//   OVERSAMPLE  16          sample ticks per bit; fixed at 16
//   DIV         CLOCK_FREQ/(BAUD*OVERSAMPLE)-1  tick divider terminal count (324 at defaults); must be >= 1
// PORTS
//   clk        in   1  system clock, rising edge
//   reset_n    in   1  asynchronous, active-low reset
//   uart_rx    in   1  asynchronous serial line; idles high
//   rx_data    out  8  last correctly framed byte; held until the next good byte
//   rx_done    out  1  one-cycle pulse: rx_data updated this cycle
//   frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
//   rx_busy    out  1  high from start-edge detection until frame end
// BEHAVIOUR
//   - Reset: rx_data=0, rx_done=0, frame_err=0, rx_busy=0; FSM=IDLE; sync FFs=1.
//   - uart_rx passes through a 2-FF synchronizer plus 1 history FF; falling edge
//     = history 1 and synchronized value 0.
//   - Tick counter counts 0..DIV and wraps. sub_cnt (0..15) advances on each wrap.
//     Both are cleared on the IDLE->START transition, aligning sampling to the edge.
//   - Bit decision: majority of the 3 samples taken at sub_cnt 7, 8, 9.
//   - FSM:
//     IDLE : rx_busy=0; falling edge -> START.
//     START: at sub_cnt 9, decide. 0 -> DATA (bit_idx=0). 1 -> false start, -> IDLE, no pulse.
//     DATA : at sub_cnt 9, shift decided bit into shift[bit_idx] (LSB first).
//            bit_idx 7 -> STOP, else bit_idx+1. sub_cnt wraps 15->0 between bits.
//     STOP : at sub_cnt 9, decide. 1 -> rx_data<=shift, rx_done=1 next cycle.
//            0 -> frame_err=1 next cycle, rx_data unchanged. Both -> IDLE.
//   - Return to IDLE happens at mid-stop-bit. A falling edge arriving in the
//     second half of the stop bit is accepted for back-to-back frames.
//   - rx_done and frame_err are mutually exclusive, each exactly 1 clk wide.
//   - Line held low (break): STOP decides 0 -> frame_err once. No new frame starts
//     until the line returns high and falls again.
//   - Latency: uart_rx falling edge to rx_done = 9 bit times + 10/16 bit time
//     + 3-4 clk (synchronizer, edge detect, output register).
//   - Reset asserted mid-frame: frame abandoned, all outputs to reset values
//     immediately. The next full frame after reset release is received normally.
//   - Tolerates a combined TX/RX rate error of at least +/-3%.
// TESTING
//   1 Loop uart_byte_tx -> uart_rx at defaults, send 0x55, 0xA3, 0x00, 0xFF:
//     rx_data equals each byte, exactly 1 rx_done per byte, frame_err never asserts.
//   2 Back-to-back frames, tx send_en asserted on tx_done, 0x01..0x10:
//     16 rx_done pulses, in order, none lost.
//   3 Low glitch of 3 us on an idle line:
//     no rx_done, no frame_err, rx_busy drops back to 0 within 1 bit time.
//   4 Hand-driven frame 0x3C with stop bit forced 0:
//     frame_err pulses once, rx_done stays 0, rx_data keeps its previous value.
//   5 Line driven at 9600*1.03 and then 9600*0.97 baud, byte 0xC6:
//     rx_data=0xC6 with rx_done in both cases.
//   6 reset_n pulsed low during data bit 4, then frame 0x7E sent:
//     outputs are 0 during reset, then 0x7E is received with a single rx_done.

Source files
------------

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampled with 3-sample majority vote
// at mid-bit. Emits each good byte with a one-cycle rx_done strobe.
module uart_byte_rx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV        = CLOCK_FREQ / (BAUD * OVERSAMPLE) - 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int TW = (DIV < 1) ? 1 : $clog2(DIV + 1);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] DIV_T = TW'(DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nxt;

  logic          sync1, sync2, hist;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] sub_cnt;
  logic          s7, s8;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic          start_clr, shift_en, good, bad;

  wire tick    = (tick_cnt == DIV_T);
  wire fall    = hist & ~sync2;
  wire dec_pt  = tick && (sub_cnt == SW'(9));
  wire bit_val = (s7 & s8) | (s7 & sync2) | (s8 & sync2);

  assign rx_busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    start_clr = 1'b0;
    shift_en  = 1'b0;
    good      = 1'b0;
    bad       = 1'b0;
    case (state)
      IDLE:  if (fall) begin
               state_nxt = START;
               start_clr = 1'b1;
             end
      START: if (dec_pt) state_nxt = bit_val ? IDLE : DATA;
      DATA:  if (dec_pt) begin
               shift_en = 1'b1;
               if (bit_idx == 3'd7) state_nxt = STOP;
             end
      STOP:  if (dec_pt) begin
               state_nxt = IDLE;
               good      = bit_val;
               bad       = ~bit_val;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      hist      <= 1'b1;
      tick_cnt  <= '0;
      sub_cnt   <= '0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      shift     <= '0;
      bit_idx   <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nxt;
      sync1 <= uart_rx;
      sync2 <= sync1;
      hist  <= sync2;
      // Counters restart on the detected edge so sub_cnt 7..9 lands mid-bit
      if (start_clr) begin
        tick_cnt <= '0;
        sub_cnt  <= '0;
      end else if (tick) begin
        tick_cnt <= '0;
        sub_cnt  <= sub_cnt + SW'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      if (tick && sub_cnt == SW'(7)) s7 <= sync2;
      if (tick && sub_cnt == SW'(8)) s8 <= sync2;
      if (start_clr) bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;
      if (shift_en) shift[bit_idx] <= bit_val;
      rx_done   <= good;
      frame_err <= bad;
      if (good) rx_data <= shift;
    end
  end
endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: framed bytes, back-to-back, glitch,
// framing error and break, baud skew, and reset mid-frame.
module tb_uart_byte_rx;
  localparam int CF   = 1_600_000;
  localparam int BD   = 25_000;
  localparam int BITC = 64;  // clocks per bit at CF/BD

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, frame_err, rx_busy;

  int checks = 0, errors = 0;
  int cyc = 0, fall_cyc = 0, done_cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [7:0] rxq[$];

  uart_byte_rx #(.CLOCK_FREQ(CF), .BAUD(BD)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .rx_data(rx_data),
    .rx_done(rx_done), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (reset_n) begin
    if (rx_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      rxq.push_back(rx_data);
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (rx_done && frame_err) both_cnt = both_cnt + 1;
  end

  // Called and returns at a falling clock edge.
  task automatic send(input logic [7:0] b, input int bc, input logic stop_v);
    uart_rx = 1'b0;
    fall_cyc = cyc;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (bc) @(negedge clk);
    end
    uart_rx = stop_v;
    repeat (bc) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic idle(input int bits);
    repeat (bits * BITC) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
    checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done got %b exp 0", rx_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy got %b exp 0", rx_busy); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_bytes;
    logic [7:0] vec [4] = '{8'h55, 8'hA3, 8'h00, 8'hFF};
    int d0, lat;
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      send(vec[i], BITC, 1'b1);
      idle(1);
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL byte%0d_done_count got %0d exp 1", i, done_cnt - d0); end
      checks++; if (rx_data !== vec[i]) begin errors++; $display("FAIL byte%0d_data got %h exp %h", i, rx_data, vec[i]); end
      // edge to strobe: 9 bits + 10/16 bit + 3..4 clk = 619..620 clk
      lat = done_cyc - fall_cyc;
      checks++; if (lat < 619 || lat > 620) begin errors++; $display("FAIL byte%0d_latency got %0d exp 619..620", i, lat); end
    end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL bytes_frame_err got %0d exp 0", err_cnt); end
  endtask

  task automatic test_back_to_back;
    rxq.delete();
    for (int i = 1; i <= 16; i++) send(8'(i), BITC, 1'b1);
    idle(1);
    checks++; if (rxq.size() !== 16) begin errors++; $display("FAIL b2b_count got %0d exp 16", rxq.size()); end
    for (int i = 0; i < 16 && i < rxq.size(); i++) begin
      checks++; if (rxq[i] !== 8'(i + 1)) begin errors++; $display("FAIL b2b_order[%0d] got %h exp %h", i, rxq[i], 8'(i + 1)); end
    end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL b2b_frame_err got %0d exp 0", err_cnt); end
  endtask

  task automatic test_glitch;
    int d0 = done_cnt, e0 = err_cnt;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise got %b exp 1", rx_busy); end
    repeat (BITC) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop got %b exp 0", rx_busy); end
    idle(1);
    checks++; if (done_cnt !== d0 || err_cnt !== e0) begin errors++; $display("FAIL glitch_pulses got done+%0d err+%0d exp 0 0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_frame_err;
    int d0 = done_cnt, e0 = err_cnt;
    send(8'h3C, BITC, 1'b0);
    idle(1);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", err_cnt - e0); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL ferr_done got %0d exp 0", done_cnt - d0); end
    checks++; if (rx_data !== 8'h10) begin errors++; $display("FAIL ferr_data_held got %h exp 10", rx_data); end
    // break: line low for 15 bit times yields one frame_err and nothing more
    e0 = err_cnt;
    uart_rx = 1'b0;
    idle(15);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL break_err_count got %0d exp 1", err_cnt - e0); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_busy got %b exp 0", rx_busy); end
    uart_rx = 1'b1;
    idle(2);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL break_done got %0d exp 0", done_cnt - d0); end
  endtask

  task automatic test_rate;
    int bcs [2] = '{62, 66};  // ~+3% and ~-3% line rate
    int d0;
    for (int i = 0; i < 2; i++) begin
      d0 = done_cnt;
      send(8'hC6, bcs[i], 1'b1);
      idle(1);
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rate%0d_done got %0d exp 1", bcs[i], done_cnt - d0); end
      checks++; if (rx_data !== 8'hC6) begin errors++; $display("FAIL rate%0d_data got %h exp c6", bcs[i], rx_data); end
    end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pulse_overlap got %0d exp 0", both_cnt); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b = 8'hA5;
    int d0;
    uart_rx = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      repeat (BITC) @(negedge clk);
    end
    uart_rx = b[4];
    repeat (BITC / 2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", rx_busy); end
    checks++; if (rx_done !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL midrst_pulses got %b%b exp 00", rx_done, frame_err); end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    d0 = done_cnt;
    send(8'h7E, BITC, 1'b1);
    idle(1);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL postrst_done got %0d exp 1", done_cnt - d0); end
    checks++; if (rx_data !== 8'h7E) begin errors++; $display("FAIL postrst_data got %h exp 7e", rx_data); end
  endtask

  initial begin
    test_reset;
    test_bytes;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_rate;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
